// File: rtl/nibble_serial_cmp_ctrl_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
// Result one-hot encoding is {y2,y1,y0} = {lt,eq,gt}.
package cmp_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  localparam logic [2:0] RES_GT = 3'b001;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b100;

  // One-hot outcome of a single nibble compare, laid out like {y2,y1,y0}
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } slice_res_t;

endpackage

// File: rtl/nibble_serial_cmp_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_cmp_ctrl.
// slave: the controller; master: the producer/consumer side.
interface nibble_serial_cmp_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CW = $clog2(WIDTH / 4 + 1);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic             y0;
  logic             y1;
  logic             y2;
  logic [CW-1:0]    cyc_cnt;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, y0, y1, y2, cyc_cnt
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, y0, y1, y2, cyc_cnt
  );

endinterface

// File: rtl/nibble_serial_cmp_ctrl_slice.sv
// Combinational 4-bit unsigned magnitude compare; the only compare hardware
// in the controller. Output is one-hot {lt,eq,gt}.
module nibble_cmp_slice
  import cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output slice_res_t       res_c
);

  always_comb begin
    res_c    = '0;
    res_c.gt = (a > b);
    res_c.eq = (a == b);
    res_c.lt = (a < b);
  end

endmodule

// File: rtl/nibble_serial_cmp_ctrl.sv
// Serial WIDTH-bit unsigned comparator walking one nibble per cycle, MSB first.
// Build option: define CMP_EARLY_EXIT_EN to leave CMP on the first differing nibble.
module nibble_serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_cmp_ctrl_if.slave bus
);

  localparam int unsigned NIB = WIDTH / NIB_W;
  localparam int unsigned CW  = $clog2(NIB + 1);
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             sticky_gt;
  logic             sticky_lt;
  logic             res_valid;
  logic             y0;
  logic             y1;
  logic             y2;
  logic [CW-1:0]    cyc_cnt;

  slice_res_t slice_c;
  logic       decided_c;
  logic       gt_now_c;
  logic       eq_now_c;
  logic       lt_now_c;
  logic       last_c;

  nibble_cmp_slice u_slice (
    .a     (a_r[NIB_W*int'(idx) +: NIB_W]),
    .b     (b_r[NIB_W*int'(idx) +: NIB_W]),
    .res_c (slice_c)
  );

  // Sticky merge: the first differing nibble owns the result
  always_comb begin
    decided_c = sticky_gt | sticky_lt;
    gt_now_c  = sticky_gt | (~decided_c & slice_c.gt);
    lt_now_c  = sticky_lt | (~decided_c & slice_c.lt);
    eq_now_c  = ~decided_c & slice_c.eq;
`ifdef CMP_EARLY_EXIT_EN
    last_c    = (idx == '0) | ~slice_c.eq;
`else
    last_c    = (idx == '0);
`endif
  end

  assign bus.start_ready = (state == IDLE) && !rst;
  assign bus.res_valid   = res_valid;
  assign bus.y0          = y0;
  assign bus.y1          = y1;
  assign bus.y2          = y2;
  assign bus.cyc_cnt     = cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= IW'(NIB - 1);
      sticky_gt <= 1'b0;
      sticky_lt <= 1'b0;
      res_valid <= 1'b0;
      y0        <= 1'b0;
      y1        <= 1'b0;
      y2        <= 1'b0;
      cyc_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_r       <= bus.a;
            b_r       <= bus.b;
            idx       <= IW'(NIB - 1);
            sticky_gt <= 1'b0;
            sticky_lt <= 1'b0;
            y0        <= 1'b0;
            y1        <= 1'b0;
            y2        <= 1'b0;
            cyc_cnt   <= '0;
            state     <= CMP;
          end
        end
        CMP: begin
          cyc_cnt   <= cyc_cnt + CW'(1);
          sticky_gt <= gt_now_c;
          sticky_lt <= lt_now_c;
          if (last_c) begin
            y0        <= gt_now_c;
            y1        <= eq_now_c;
            y2        <= lt_now_c;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          // Result held until the consumer takes it
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_cmp_ctrl.sv
// Directed bench for nibble_serial_cmp_ctrl at WIDTH=16; honours CMP_EARLY_EXIT_EN.
module tb_nibble_serial_cmp_ctrl;
  import cmp_pkg::*;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  nibble_serial_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int k_of(input int early_k);
`ifdef CMP_EARLY_EXIT_EN
    return early_k;
`else
    return 4;
`endif
  endfunction

  // Accept a,b then wait for res_valid; lat is the edge count after accept, -1 on timeout
  task automatic do_cmp(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [2:0] y, output logic [2:0] cnt);
    int n;
    n = 0;
    lat = -1;
    while (!bus.start_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (bus.start_ready) begin
      bus.a = a; bus.b = b; bus.start_valid = 1'b1;
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      bus.a = ~a; bus.b = ~b;
      for (int i = 1; i <= 20; i++) begin
        if (bus.res_valid) break;
        @(posedge clk); #1;
        if (bus.res_valid) begin
          lat = i;
          break;
        end
      end
    end
    y   = {bus.y2, bus.y1, bus.y0};
    cnt = bus.cyc_cnt;
  endtask

  task automatic handshake(output logic rv_after, output logic sr_after);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    rv_after = bus.res_valid;
    sr_after = bus.start_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.y2, bus.y1, bus.y0, bus.cyc_cnt, bus.start_ready} !== 8'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: rv=%b y=%b%b%b cnt=%0d sr=%b, want all 0",
                 c, bus.res_valid, bus.y2, bus.y1, bus.y0, bus.cyc_cnt, bus.start_ready);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.start_ready);
    end
  endtask

  task automatic test_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] exp_y, input int exp_k);
    int lat; logic [2:0] y; logic [2:0] cnt; logic rv; logic sr;
    do_cmp(a, b, lat, y, cnt);
    checks++;
    if (lat !== exp_k) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_k);
    end
    checks++;
    if (y !== exp_y) begin
      errors++;
      $display("FAIL %s_result: got %b want %b", name, y, exp_y);
    end
    checks++;
    if (cnt !== 3'(exp_k)) begin
      errors++;
      $display("FAIL %s_cyc_cnt: got %0d want %0d", name, cnt, exp_k);
    end
    handshake(rv, sr);
    checks++;
    if ({rv, sr} !== 2'b01) begin
      errors++;
      $display("FAIL %s_handshake: rv=%b sr=%b want rv=0 sr=1", name, rv, sr);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [2:0] y; logic [2:0] cnt; logic rv; logic sr;
    logic [2:0] exp_y;
    exp_y = RES_GT;
    do_cmp(16'h9000, 16'h8FFF, lat, y, cnt);
    checks++;
    if (lat !== k_of(1)) begin
      errors++;
      $display("FAIL bp_latency: got %0d want %0d", lat, k_of(1));
    end
    bus.start_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.a = 16'(c * 16'h1111); bus.b = ~bus.a;
      @(posedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.start_ready, bus.y2, bus.y1, bus.y0, bus.cyc_cnt}
          !== {1'b1, 1'b0, exp_y, 3'(k_of(1))}) begin
        errors++;
        $display("FAIL bp_hold_%0d: rv=%b sr=%b y=%b%b%b cnt=%0d want rv=1 sr=0 y=%b cnt=%0d",
                 c, bus.res_valid, bus.start_ready, bus.y2, bus.y1, bus.y0, bus.cyc_cnt,
                 exp_y, k_of(1));
      end
    end
    bus.start_valid = 1'b0;
    handshake(rv, sr);
    checks++;
    if ({rv, sr} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: rv=%b sr=%b want rv=0 sr=1", rv, sr);
    end
    test_vec("bp_next", 16'h0001, 16'h0002, RES_LT, 4);
  endtask

  task automatic test_reset_mid_cmp();
    bus.a = 16'h1234; bus.b = 16'h1234; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.res_valid, bus.start_ready, bus.y2, bus.y1, bus.y0, bus.cyc_cnt} !== 8'b0) begin
      errors++;
      $display("FAIL midrst_state: rv=%b sr=%b y=%b%b%b cnt=%0d want all 0",
               bus.res_valid, bus.start_ready, bus.y2, bus.y1, bus.y0, bus.cyc_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.start_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got %b want 1", bus.start_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.res_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_result_%0d: rv=%b want 0", c, bus.res_valid);
      end
    end
    test_vec("midrst_next", 16'h0F00, 16'h1000, RES_LT, k_of(1));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_vec("equal",     16'h1234, 16'h1234, RES_EQ, 4);
    test_vec("gt_msb",    16'h9000, 16'h8FFF, RES_GT, k_of(1));
    test_vec("lt_lsb",    16'h00A0, 16'h00A1, RES_LT, 4);
    test_vec("lt_msb",    16'h0F00, 16'h1000, RES_LT, k_of(1));
    test_vec("gt_sticky", 16'h1300, 16'h12FF, RES_GT, k_of(2));
    test_vec("lt_third",  16'h1230, 16'h1240, RES_LT, k_of(3));
    test_vec("gt_max",    16'hFFFF, 16'h0000, RES_GT, k_of(1));
    test_backpressure();
    test_reset_mid_cmp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
